// File: rtl/icache_responder_if.sv
// rtl/icache_responder_if.sv - fetch and refill bus bundle for icache_responder
interface icache_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pc_addr;
    logic                  pc_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  flush;
    logic                  mem_req_valid;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport slave (
        input  pc_addr, pc_valid, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output instr, instr_valid, mem_req_valid, mem_req_addr
    );

    modport master (
        output pc_addr, pc_valid, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  instr, instr_valid, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only icache answering PC fetches
module icache_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    icache_responder_if.slave  bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, RESP} state_t;

    state_t                  r_state, w_next;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [DATA_WIDTH-1:0]   r_data [LINES*WORDS_PER_LINE];
    logic [DATA_WIDTH-3:0]   r_req_word;
    logic [DATA_WIDTH-1:0]   r_instr;
    logic [OFF_W-1:0]        r_cnt;
    logic                    r_flush_seen;

    logic [OFF_W-1:0]        w_pc_off, w_req_off;
    logic [IDX_W-1:0]        w_pc_idx, w_req_idx;
    logic [TAG_W-1:0]        w_pc_tag, w_req_tag;
    logic                    w_hit, w_last, w_fill_we, w_unused_pc_lsb;

    assign w_pc_off  = bus.pc_addr[OFF_W+1:2];
    assign w_pc_idx  = bus.pc_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign w_pc_tag  = bus.pc_addr[DATA_WIDTH-1:IDX_W+OFF_W+2];
    assign w_req_off = r_req_word[OFF_W-1:0];
    assign w_req_idx = r_req_word[IDX_W+OFF_W-1:OFF_W];
    assign w_req_tag = r_req_word[DATA_WIDTH-3:IDX_W+OFF_W];
    assign w_unused_pc_lsb = ^bus.pc_addr[1:0];

    // Lookup sees the valid bits before any same-cycle flush takes effect
    assign w_hit     = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
    assign w_last    = (r_cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign w_fill_we = (r_state == FILL_WAIT) && bus.mem_resp_valid;

    assign bus.instr         = r_instr;
    assign bus.instr_valid   = (r_state == RESP);
    assign bus.mem_req_valid = (r_state == FILL_REQ);
    assign bus.mem_req_addr  = {w_req_tag, w_req_idx, r_cnt, 2'b00};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.pc_valid) w_next = w_hit ? RESP : FILL_REQ;
            FILL_REQ:  if (bus.mem_req_ready) w_next = FILL_WAIT;
            FILL_WAIT: if (bus.mem_resp_valid) w_next = w_last ? RESP : FILL_REQ;
            RESP:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_req_word   <= '0;
            r_instr      <= '0;
            r_cnt        <= '0;
            r_flush_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.pc_valid) begin
                        r_req_word   <= bus.pc_addr[DATA_WIDTH-1:2];
                        r_cnt        <= '0;
                        r_flush_seen <= bus.flush;
                        if (w_hit) r_instr <= r_data[{w_pc_idx, w_pc_off}];
                    end
                end
                FILL_REQ: if (bus.flush) r_flush_seen <= 1'b1;
                FILL_WAIT: begin
                    if (bus.flush) r_flush_seen <= 1'b1;
                    if (bus.mem_resp_valid) begin
                        if (r_cnt == w_req_off) r_instr <= bus.mem_resp_data;
                        if (!w_last) r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // A flush anywhere in the fill leaves the refilled line invalid
            if (bus.flush)
                r_valid <= '0;
            else if (w_fill_we && w_last && !r_flush_seen)
                r_valid[w_req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{w_req_idx, r_cnt}] <= bus.mem_resp_data;
            if (w_last) r_tag[w_req_idx] <= w_req_tag;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - directed vector bench for icache_responder
module tb_icache_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_responder_if #(.DATA_WIDTH(32)) bus ();

    icache_responder #(.DATA_WIDTH(32), .LINES(64), .WORDS_PER_LINE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          flush_with;
        bit          flush_mid;
        int          bp;
        logic [31:0] exp_instr;
        int          exp_reqs;
    } vec_t;

    vec_t vecs [14];
    int   n_vec = 0;
    int   n_fail = 0;

    int          fetch_id = 0;
    int          bp_cycles = 0;
    logic [31:0] req_q [$];
    logic [31:0] stall_q [$];
    int          resp_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] hi;
        hi = ((a >> 4) ^ 32'h10) << 8;
        return hi | (32'hA0 + {28'h0, a[3:2]});
    endfunction

    // Memory: one-cycle response to every accepted request, optional stall on word 1
    initial begin
        int          seen_id;
        bit          pending;
        logic [31:0] pend_addr;
        seen_id = 0;
        pending = 0;
        pend_addr = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        forever begin
            @(negedge clk);
            if (fetch_id != seen_id) begin
                seen_id = fetch_id;
                req_q.delete();
                stall_q.delete();
                resp_cnt = 0;
            end
            if (!rst_n) begin
                pending = 0;
                bus.mem_req_ready = 1'b0;
                bus.mem_resp_valid = 1'b0;
                bus.mem_resp_data = '0;
            end else begin
                bus.mem_resp_valid = pending;
                bus.mem_resp_data = pending ? mem_word(pend_addr) : 32'h0;
                if (pending) resp_cnt++;
                pending = 0;
                if (bus.mem_req_valid && bus.mem_req_addr[3:2] == 2'd1 && stall_q.size() < bp_cycles) begin
                    bus.mem_req_ready = 1'b0;
                    stall_q.push_back(bus.mem_req_addr);
                end else begin
                    bus.mem_req_ready = 1'b1;
                    if (bus.mem_req_valid) begin
                        pending = 1;
                        pend_addr = bus.mem_req_addr;
                        req_q.push_back(bus.mem_req_addr);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_fetch(input vec_t v, input string name);
        int          lat;
        bit          seen;
        logic [31:0] got;
        logic [31:0] base;
        base = {v.addr[31:4], 4'h0};
        got = '0;
        fetch_id++;
        bp_cycles = v.bp;
        bus.pc_addr = v.addr;
        bus.pc_valid = 1'b1;
        bus.flush = v.flush_with;
        lat = 0;
        seen = 0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            bus.pc_valid = 1'b0;
            bus.flush = v.flush_mid && (lat == 4);
            bus.pc_addr = ~v.addr;
            if (bus.instr_valid) begin
                seen = 1;
                got = bus.instr;
            end
        end
        check({name, "_seen"}, {31'h0, seen}, 32'h1);
        check({name, "_instr"}, got, v.exp_instr);
        if (v.exp_reqs == 0) check({name, "_hit_lat"}, lat, 32'd1);
        @(negedge clk);
        check({name, "_pulse"}, {31'h0, bus.instr_valid}, 32'h0);
        check({name, "_hold"}, bus.instr, got);
        check({name, "_nreq"}, req_q.size(), v.exp_reqs);
        check({name, "_nresp"}, resp_cnt, v.exp_reqs);
        for (int i = 0; i < v.exp_reqs && i < req_q.size(); i++)
            check({name, "_reqaddr"}, req_q[i], base + 32'(i * 4));
        if (v.bp > 0) begin
            check({name, "_nstall"}, stall_q.size(), v.bp);
            for (int i = 0; i < stall_q.size(); i++)
                check({name, "_stalladdr"}, stall_q[i], base + 32'h4);
        end
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{32'h0000_0108, 1'b0, 1'b0, 0, 32'h0000_00A2, 4};
        vecs[1]  = '{32'h0000_010C, 1'b0, 1'b0, 0, 32'h0000_00A3, 0};
        vecs[2]  = '{32'h0000_0101, 1'b0, 1'b0, 0, 32'h0000_00A0, 0};
        vecs[3]  = '{32'h0000_0500, 1'b0, 1'b0, 0, 32'h0000_40A0, 4};
        vecs[4]  = '{32'h0000_0108, 1'b0, 1'b0, 0, 32'h0000_00A2, 4};
        vecs[5]  = '{32'h0000_0304, 1'b0, 1'b0, 3, 32'h0000_20A1, 4};
        vecs[6]  = '{32'h0000_030C, 1'b0, 1'b0, 0, 32'h0000_20A3, 0};
        vecs[7]  = '{32'h0000_0200, 1'b0, 1'b1, 0, 32'h0000_30A0, 4};
        vecs[8]  = '{32'h0000_0200, 1'b0, 1'b0, 0, 32'h0000_30A0, 4};
        vecs[9]  = '{32'h0000_0204, 1'b0, 1'b0, 0, 32'h0000_30A1, 0};
        vecs[10] = '{32'h0000_0208, 1'b1, 1'b0, 0, 32'h0000_30A2, 0};
        vecs[11] = '{32'h0000_0208, 1'b0, 1'b0, 0, 32'h0000_30A2, 4};
        vecs[12] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 0, 32'hFFFF_EFA3, 4};
        vecs[13] = '{32'hFFFF_FFF0, 1'b0, 1'b0, 0, 32'hFFFF_EFA0, 0};

        bus.pc_addr = '0;
        bus.pc_valid = 1'b0;
        bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        check("rst_req_addr", bus.mem_req_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            do_fetch(vecs[i], $sformatf("vec%0d", i));

        fetch_id++;
        bp_cycles = 0;
        bus.pc_addr = 32'h0000_0400;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        check("midrst_req_before", {31'h0, bus.mem_req_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        check("midrst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{32'h0000_0400, 1'b0, 1'b0, 0, 32'h0000_50A0, 4};
        do_fetch(v, "after_rst_0400");
        v = '{32'h0000_010C, 1'b0, 1'b0, 0, 32'h0000_00A3, 4};
        do_fetch(v, "after_rst_010c");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache side of the PC↔icache fetch interface; answers fetch requests from the PC register.
- Direct-mapped, read-only cache. Valid and tag arrays in flops; data array is an inferred register array.
- On a miss, refills the whole line from the instruction memory bus, one word at a time with a valid/ready handshake.
- Sits between the PC/fetch stage and the memory arbiter.

Parameters:
- DATA_WIDTH, 32, address and instruction width.
- LINES, 64, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pc_addr  in  DATA_WIDTH  fetch byte address; bits [1:0] are ignored
- pc_valid  in  1  fetch request; the PC drives it as ~instr_valid
- instr  out  DATA_WIDTH  fetched instruction, valid while instr_valid=1
- instr_valid  out  1  single-cycle response pulse
- flush  in  1  invalidate all lines
- mem_req_valid  out  1  memory word-read request
- mem_req_addr  out  DATA_WIDTH  word-aligned request address
- mem_req_ready  in  1  memory accepts the request
- mem_resp_valid  in  1  read data returned (in order, one per accepted request)
- mem_resp_data  in  DATA_WIDTH  read data

Behaviour:
- Address split (defaults):
  - word offset = addr[3:2]
  - index = addr[9:4]
  - tag = addr[31:10]
  - widths derive from $clog2 of the parameters.
- Reset (async) values:
  - state IDLE; all valid bits 0
  - instr=0, instr_valid=0
  - mem_req_valid=0, mem_req_addr=0
  - tag and data arrays are not reset.
- State machine: IDLE, FILL_REQ, FILL_WAIT, RESP.
- IDLE:
  - pc_valid=1 samples pc_addr into req_addr.
  - On a hit (valid[index] and tag match), the word is registered into instr and the FSM enters RESP. Hit latency is 1: instr_valid is high the cycle after sampling.
  - On a miss, the FSM enters FILL_REQ with word counter=0.
- FILL_REQ:
  - mem_req_valid=1, mem_req_addr={req tag, req index, counter, 2'b00}.
  - Address is stable until mem_req_ready=1 in the same cycle; then go to FILL_WAIT.
- FILL_WAIT:
  - On mem_resp_valid, write mem_resp_data into data[index][counter].
  - If the counter equals the requested word, also capture the data into instr.
  - If the counter is the last word: set tag[index], set valid[index] unless a flush occurred during this fill, and go to RESP.
  - Otherwise increment the counter and go to FILL_REQ.
  - Fill order is always word 0..N-1; there is no critical-word-first.
- RESP:
  - instr_valid=1 for exactly one cycle, then IDLE.
  - pc_valid is low in this cycle by protocol; if it is high anyway, it is ignored.
- instr holds its last value when instr_valid=0.
- pc_addr changes during a miss are ignored; the response always matches the latched req_addr.
- flush:
  - Clears all valid bits the next cycle, in any state.
  - A fill in progress completes and returns its instruction, but that line is left invalid.
  - flush together with a hit lookup in IDLE: the lookup uses the pre-flush valid bits (hit served).
- mem_resp_valid outside FILL_WAIT is ignored.
- Only one memory request is outstanding at a time.
- Reset mid-fill: returns to IDLE immediately, drops mem_req_valid, and leaves nothing valid.
- Misaligned pc_addr: low 2 bits are dropped; this is not an error.

Test Plan:
- Cold miss: reset, pc_valid=1, pc_addr=0x0000_0108, memory returns 0xA0+w for word w with ready=1 and 1-cycle response → 4 requests to 0x100, 0x104, 0x108, 0x10C in order; instr_valid pulses once with instr=0xA2; valid[16] is set.
- Hit after fill: pc_addr=0x0000_010C → instr_valid exactly 1 cycle after sampling, instr=0xA3, no mem_req_valid.
- Conflict eviction: fetch 0x0000_0500 (same index 16, different tag) → miss and refill; a refetch of 0x108 then misses again.
- Backpressure: mem_req_ready low for 3 cycles on word 1 → mem_req_addr held at word 1's address; no duplicate write; the final instr is correct.
- Flush during fill: assert flush while in FILL_WAIT for 0x200 → instr is still returned; a refetch of 0x200 misses.
- Reset mid-fill: deassert rst_n during FILL_REQ → mem_req_valid=0 and instr_valid=0 at once; after release, a fetch of that address misses.
